hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It drives the write-enables and flushes of the PC, IF/ID and ID/EX registers, and the global freeze. It resolves four conditions: load-use hazards between ID and EX, taken branches/jumps redirected from EX, data-memory wait states from MEM, and a debug halt/drain handshake. It replaces the hand-wired `pc_write_zero`/`IFID_pipeline_write_zero` stall paths with one priority-ordered controller.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Priority-ordered pipeline hazard controller: memory freeze, EX redirect, load-use
// stall and debug halt/drain FSM. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic       uses_rs1_D,
  input  logic       uses_rs2_D,
  input  logic [4:0] rd_E,
  input  logic       mem_re_E,
  input  logic       redirect_E,
  input  logic       mem_busy_M,
  input  logic       halt_req,
  output logic       pc_write_en,
  output logic       ifid_write_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pipe_freeze,
  output logic       halt_ack,
  output logic       mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] lu_stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] freeze_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES);
  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_nxt;
  logic [7:0] busy_cnt, busy_nxt;
  logic       lu;

  assign lu = mem_re_E && (rd_E != '0) &&
              ((uses_rs1_D && (rs1_D == rd_E)) || (uses_rs2_D && (rs2_D == rd_E)));

  assign busy_nxt = !mem_busy_M ? '0 :
                    (busy_cnt == '1) ? busy_cnt : busy_cnt + 8'd1;

  always_comb begin
    pc_write_en   = 1'b0;
    ifid_write_en = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pipe_freeze   = 1'b0;
    if (mem_busy_M) begin
      pipe_freeze = 1'b1;
    end else if (redirect_E) begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
    end else if (lu) begin
      idex_flush = 1'b1;
    end else if (state == RUN) begin
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
    end else begin
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b1;
    end
    if (reset) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      pipe_freeze   = 1'b0;
    end
  end

  // A frozen pipeline holds the FSM in every state; halt_req dropping wins over redirect.
  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    if (!mem_busy_M) begin
      unique case (state)
        RUN: begin
          if (halt_req) begin
            state_nxt = DRAIN;
            drain_nxt = DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (!halt_req) begin
            state_nxt = RUN;
          end else if (redirect_E) begin
            drain_nxt = DRAIN_LOAD;
          end else if (!lu) begin
            drain_nxt = drain_cnt - 4'd1;
            if (drain_cnt == 4'd1) state_nxt = HALTED;
          end
        end
        HALTED: begin
          if (!halt_req) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      drain_cnt       <= '0;
      busy_cnt        <= '0;
      halt_ack        <= 1'b0;
      mem_timeout_err <= 1'b0;
    end else begin
      state           <= state_nxt;
      drain_cnt       <= drain_nxt;
      busy_cnt        <= busy_nxt;
      halt_ack        <= (state_nxt == HALTED);
      mem_timeout_err <= mem_timeout_err || (busy_nxt == TIMEOUT_VAL);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_stall_cnt <= '0;
      flush_cnt    <= '0;
      freeze_cnt   <= '0;
    end else if (state != HALTED) begin
      if (mem_busy_M) begin
        if (freeze_cnt != '1) freeze_cnt <= freeze_cnt + 16'd1;
      end else if (redirect_E) begin
        if (flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
      end else if (lu) begin
        if (lu_stall_cnt != '1) lu_stall_cnt <= lu_stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard/halt scenarios plus random traffic,
// every cycle compared against a behavioural model of the controller rules.
module tb_hazard_ctrl;
  localparam int unsigned DC = 3;
  localparam int unsigned MT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_D, rs2_D, rd_E;
  logic       uses_rs1_D, uses_rs2_D, mem_re_E, redirect_E, mem_busy_M, halt_req;
  logic       pc_write_en, ifid_write_en, ifid_flush, idex_flush, pipe_freeze;
  logic       halt_ack, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] lu_stall_cnt, flush_cnt, freeze_cnt;
`endif

  hazard_ctrl #(.DRAIN_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset(reset),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .uses_rs1_D(uses_rs1_D), .uses_rs2_D(uses_rs2_D),
    .rd_E(rd_E), .mem_re_E(mem_re_E), .redirect_E(redirect_E),
    .mem_busy_M(mem_busy_M), .halt_req(halt_req),
    .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_freeze(pipe_freeze),
    .halt_ack(halt_ack), .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt(lu_stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: halting/halted flags, remaining drain slots, run length of memory busy
  bit m_draining, m_halted, m_ack, m_err;
  int m_left, m_busy_run;
  int m_lu, m_fl, m_fz;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit load_use();
    return mem_re_E && (rd_E != 5'd0) &&
           ((uses_rs1_D && rs1_D == rd_E) || (uses_rs2_D && rs2_D == rd_E));
  endfunction

  task automatic idle_inputs();
    rs1_D = 0; rs2_D = 0; rd_E = 0; uses_rs1_D = 0; uses_rs2_D = 0;
    mem_re_E = 0; redirect_E = 0; mem_busy_M = 0;
  endtask

  task automatic model_reset();
    m_draining = 0; m_halted = 0; m_ack = 0; m_err = 0;
    m_left = 0; m_busy_run = 0; m_lu = 0; m_fl = 0; m_fz = 0;
  endtask

  // One clock: compare at negedge, then advance the model across the posedge.
  task automatic cyc();
    bit lu, e_pc, e_ifw, e_iff, e_idf, e_frz;
    @(negedge clk);
    lu = load_use();
    e_pc = 0; e_ifw = 0; e_iff = 0; e_idf = 0; e_frz = 0;
    if (mem_busy_M) e_frz = 1;
    else if (redirect_E) begin e_pc = 1; e_ifw = 1; e_iff = 1; e_idf = 1; end
    else if (lu) e_idf = 1;
    else if (!m_draining && !m_halted) begin e_pc = 1; e_ifw = 1; end
    else begin e_ifw = 1; e_iff = 1; end
    chk("pc_write_en", pc_write_en, e_pc);
    chk("ifid_write_en", ifid_write_en, e_ifw);
    chk("ifid_flush", ifid_flush, e_iff);
    chk("idex_flush", idex_flush, e_idf);
    chk("pipe_freeze", pipe_freeze, e_frz);
    chk("halt_ack", halt_ack, m_ack);
    chk("mem_timeout_err", mem_timeout_err, m_err);
`ifdef HAZARD_PERF_CNT_EN
    chk("lu_stall_cnt", lu_stall_cnt, 16'(m_lu));
    chk("flush_cnt", flush_cnt, 16'(m_fl));
    chk("freeze_cnt", freeze_cnt, 16'(m_fz));
`endif
    @(posedge clk);
    if (!m_halted) begin
      if (mem_busy_M) m_fz = (m_fz < 65535) ? m_fz + 1 : m_fz;
      else if (redirect_E) m_fl = (m_fl < 65535) ? m_fl + 1 : m_fl;
      else if (lu) m_lu = (m_lu < 65535) ? m_lu + 1 : m_lu;
    end
    m_busy_run = mem_busy_M ? ((m_busy_run < 255) ? m_busy_run + 1 : 255) : 0;
    if (m_busy_run == MT) m_err = 1;
    if (!mem_busy_M) begin
      if (m_halted) begin
        if (!halt_req) m_halted = 0;
      end else if (m_draining) begin
        if (!halt_req) m_draining = 0;
        else if (redirect_E) m_left = DC;
        else if (!lu) begin
          m_left--;
          if (m_left == 0) begin m_draining = 0; m_halted = 1; end
        end
      end else if (halt_req) begin
        m_draining = 1;
        m_left = DC;
      end
    end
    m_ack = m_halted;
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    halt_req = 0;
    reset = 1;
    model_reset();
    #2;
    chk("rst_pc_write_en", pc_write_en, 0);
    chk("rst_ifid_write_en", ifid_write_en, 0);
    chk("rst_halt_ack", halt_ack, 0);
    chk("rst_mem_timeout_err", mem_timeout_err, 0);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle_inputs();
    halt_req = 0;
    reset = 1;
    model_reset();
    #1;
    chk("por_pipe_freeze", pipe_freeze, 0);
    chk("por_idex_flush", idex_flush, 0);
    apply_reset();
    cyc();

    // load x5 then add x6,x5,x1: one stall cycle, bubble follows
    rd_E = 5; mem_re_E = 1; rs1_D = 5; uses_rs1_D = 1; rs2_D = 1; uses_rs2_D = 1;
    cyc();
    mem_re_E = 0; rd_E = 0;
    cyc();
    // same pattern with rd_E = 0 and via rs2
    rd_E = 0; mem_re_E = 1; rs1_D = 0;
    cyc();
    rd_E = 7; rs1_D = 3; rs2_D = 7;
    cyc();
    // redirect together with load-use: flush wins
    redirect_E = 1;
    cyc();
    idle_inputs();
    cyc();

    // 16 busy cycles: timeout flag sticks afterwards
    mem_busy_M = 1; redirect_E = 1; mem_re_E = 1; rd_E = 2; rs1_D = 2; uses_rs1_D = 1;
    for (int i = 0; i < 16; i++) cyc();
    idle_inputs();
    cyc(); cyc();
    chk("err_sticky", mem_timeout_err, 1);

    // plain halt: ack after DC+1 cycles
    halt_req = 1;
    n = 0;
    do begin cyc(); n++; end while (!halt_ack && n < 20);
    chk("halt_latency", 16'(n), 16'(DC + 1));
    cyc(); cyc();
    halt_req = 0;
    cyc();
    chk("ack_drop", halt_ack, 0);
    cyc();

    // halt with a 2-cycle memory stall inside DRAIN
    halt_req = 1;
    cyc(); cyc();
    mem_busy_M = 1;
    cyc(); cyc();
    mem_busy_M = 0;
    n = 4;
    do begin cyc(); n++; end while (!halt_ack && n < 20);
    chk("halt_latency_busy", 16'(n), 16'(DC + 3));
    halt_req = 0;
    cyc(); cyc();

    // redirect in the second DRAIN cycle restarts the drain
    halt_req = 1;
    cyc(); cyc();
    redirect_E = 1;
    cyc();
    redirect_E = 0;
    n = 3;
    do begin cyc(); n++; end while (!halt_ack && n < 20);
    chk("halt_latency_redirect", 16'(n), 16'(DC + 3));
    cyc();

    // asynchronous reset while HALTED
    @(negedge clk);
    #2;
    reset = 1;
    #1;
    chk("async_halt_ack", halt_ack, 0);
    chk("async_ifid_flush", ifid_flush, 0);
    chk("async_timeout", mem_timeout_err, 0);
    apply_reset();
    cyc();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rs1_D      = 5'($urandom_range(0, 3));
      rs2_D      = 5'($urandom_range(0, 3));
      rd_E       = 5'($urandom_range(0, 3));
      uses_rs1_D = 1'($urandom_range(0, 1));
      uses_rs2_D = 1'($urandom_range(0, 1));
      mem_re_E   = 1'($urandom_range(0, 1));
      redirect_E = ($urandom_range(0, 7) == 0);
      mem_busy_M = ($urandom_range(0, 5) == 0) || (i >= 400 && i < 420);
      if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
      cyc();
    end

    apply_reset();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
